led_run_ctrl: RTL
=================

// Module: led_run_ctrl
// PURPOSE
//  Sequencer for the 4-bit LED runner. Produces a prescaled one-cycle step strobe
//  and a direction select (0 = shift left, 1 = shift right) so the runner bounces:
//  STEPS steps left, then STEPS steps right, which is one lap, for LAPS laps.
//  Sits between the user controls (start/stop/pause) and the runner's step/mode inputs.
// PARAMETERS
//  DIV    25_000_000  clk cycles per step; legal range 2 .. 2^DIV_W-1
//  DIV_W  25          width of the prescaler counter
//  STEPS  4           steps per direction; legal range 1..255
//  LAPS   3           laps per run; 0 = run until stop_i
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  synchronous reset, active-high
//  start_i    in   1  start request (level or pulse); acted on only in IDLE
//  stop_i     in   1  abort run; highest priority after rst
//  pause_i    in   1  level; freezes sequencing while high
//  step_o     out  1  one-cycle strobe; runner advances one position
//  mode_o     out  1  0 = left, 1 = right; stable whenever step_o=1
//  busy_o     out  1  1 while in LEFT or RIGHT
//  lap_o      out  1  one-cycle pulse after each completed lap
//  done_o     out  1  one-cycle pulse when LAPS laps are complete
//  lap_cnt_o  out  8  completed laps in the current or last run; wraps 255->0
// BEHAVIOUR
//  - All outputs registered. rst: state=IDLE, div_cnt=0, step_cnt=0, every output 0.
//  - FSM states: IDLE, LEFT, RIGHT, DONE. mode_o=1 only in RIGHT. busy_o=1 in LEFT and RIGHT.
//  - IDLE: on start_i=1, go to LEFT and clear div_cnt, step_cnt and lap_cnt_o.
//  - LEFT/RIGHT with pause_i=0: div_cnt counts 0..DIV-1, then wraps.
//    step_o=1 in the cycle after div_cnt==DIV-1. First step_o comes DIV+1 cycles after start_i is sampled.
//  - On each edge where step_o=1: step_cnt++.
//    If step_cnt==STEPS-1, step_cnt<=0 and the state changes. mode_o therefore changes
//    only in the cycle after the last strobe of a direction, never while step_o=1.
//  - LEFT last step: go to RIGHT.
//  - RIGHT last step: lap_cnt_o++ and lap_o=1 next cycle. Then:
//    if LAPS!=0 and the new count==LAPS, go to DONE; otherwise go to LEFT.
//  - DONE: done_o=1 for exactly one cycle, then go to IDLE. lap_cnt_o holds until the next start.
//  - pause_i=1 in LEFT/RIGHT: div_cnt, step_cnt and state frozen; step_o=0.
//    If pause_i rises in the same cycle a strobe would issue, the strobe is withheld
//    and issued the cycle after pause_i falls.
//  - stop_i=1 in any state: next state IDLE. Any pending or coincident step_o is suppressed.
//    No lap_o, no done_o. stop_i overrides pause_i and start_i.
//  - start_i while busy_o=1 or in DONE: ignored.
//  - rst mid-run: immediate return to reset values on the next edge, no pulses emitted.
//  - Simultaneous lap completion and LAPS reached: lap_o and done_o both pulse,
//    done_o one cycle later (DONE state).
// TESTING  (DIV=4, STEPS=4, LAPS=2 unless noted)
//  1 rst held 3 cycles -> all outputs 0, mode_o=0. Release with start_i=0 -> stays IDLE.
//  2 start_i 1-cycle pulse -> busy_o=1 next cycle; step_o every 4 cycles.
//    Steps 1-4 with mode_o=0, steps 5-8 with mode_o=1; lap_o after step 8 (lap_cnt_o=1).
//    16 steps total, then done_o for 1 cycle, busy_o=0, lap_cnt_o=2.
//  3 pause_i high 10 cycles after step 2 -> gap between steps 2 and 3 is exactly 14 cycles;
//    step count and mode sequence otherwise unchanged.
//  4 stop_i in RIGHT, in the same cycle a strobe is due -> no step_o, no lap_o/done_o, busy_o=0 next cycle.
//    Restart begins in LEFT with lap_cnt_o=0.
//  5 LAPS=0, DIV=2, STEPS=1 -> runs indefinitely, done_o never asserts.
//    lap_cnt_o wraps 255->0 after 256 laps.
//  6 start_i held high during a run -> no restart mid-run.
//    rst asserted mid-LEFT -> reset values next cycle.

Source files
------------

// File: rtl/led_run_ctrl.sv
// Step/direction sequencer for the 4-bit LED runner: prescaled step strobe,
// left/right bounce of STEPS steps each way, repeated for LAPS laps.
module led_run_ctrl #(
    parameter int DIV   = 25_000_000,
    parameter int DIV_W = 25,
    parameter int STEPS = 4,
    parameter int LAPS  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       pause_i,
    output logic       step_o,
    output logic       mode_o,
    output logic       busy_o,
    output logic       lap_o,
    output logic       done_o,
    output logic [7:0] lap_cnt_o
);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, DONE} state_t;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [7:0]       STEP_LAST   = 8'(STEPS - 1);
    localparam logic [7:0]       LAP_TARGET  = 8'(LAPS);
    localparam bit               RUN_FOREVER = (LAPS == 0);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [7:0]       step_cnt, step_nxt;
    logic [7:0]       lap_nxt;
    logic             step_nxt_o, lap_nxt_o, done_nxt_o;

    always_comb begin
        state_nxt  = state;
        div_nxt    = div_cnt;
        step_nxt   = step_cnt;
        lap_nxt    = lap_cnt_o;
        step_nxt_o = 1'b0;
        lap_nxt_o  = 1'b0;
        done_nxt_o = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = LEFT;
                    div_nxt   = '0;
                    step_nxt  = '0;
                    lap_nxt   = '0;
                end
            end
            LEFT, RIGHT: begin
                if (!pause_i) begin
                    if (div_cnt == DIV_LAST) begin
                        div_nxt    = '0;
                        step_nxt_o = 1'b1;
                    end else begin
                        div_nxt = div_cnt + 1'b1;
                    end
                end
                // A strobe already on the output has moved the runner, so it is
                // always accounted for, even if pause rose during that cycle.
                if (step_o) begin
                    if (step_cnt == STEP_LAST) begin
                        step_nxt = '0;
                        if (state == LEFT) begin
                            state_nxt = RIGHT;
                        end else begin
                            lap_nxt   = lap_cnt_o + 8'd1;
                            lap_nxt_o = 1'b1;
                            if (!RUN_FOREVER && lap_nxt == LAP_TARGET) begin
                                state_nxt = DONE;
                            end else begin
                                state_nxt = LEFT;
                            end
                        end
                    end else begin
                        step_nxt = step_cnt + 8'd1;
                    end
                end
            end
            DONE: begin
                done_nxt_o = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (stop_i) begin
            state_nxt  = IDLE;
            lap_nxt    = lap_cnt_o;
            step_nxt_o = 1'b0;
            lap_nxt_o  = 1'b0;
            done_nxt_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            step_cnt  <= '0;
            step_o    <= 1'b0;
            mode_o    <= 1'b0;
            busy_o    <= 1'b0;
            lap_o     <= 1'b0;
            done_o    <= 1'b0;
            lap_cnt_o <= '0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            step_cnt  <= step_nxt;
            step_o    <= step_nxt_o;
            mode_o    <= (state_nxt == RIGHT);
            busy_o    <= (state_nxt == LEFT) || (state_nxt == RIGHT);
            lap_o     <= lap_nxt_o;
            done_o    <= done_nxt_o;
            lap_cnt_o <= lap_nxt;
        end
    end

endmodule
